// File: rtl/bullet_pool.sv
// Pool of NUM_SLOTS projectiles fired from the player sprite, moved on each
// movement tick, retired at the map edge, and rendered as a per-pixel hit.
module bullet_pool #(
   parameter int NUM_SLOTS = 4,
   parameter int SPD       = 25,
   parameter int MAP_W     = 640,
   parameter int MAP_H     = 480,
   parameter int BW        = 10,
   parameter int BH        = 11,
   parameter int PLYR_SZ   = 60,
   parameter int COOLDOWN  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 tick,
   input  logic                 fire,
   input  logic [2:0]           fire_dir,
   input  logic [9:0]           plyr_x,
   input  logic [9:0]           plyr_y,
   input  logic [9:0]           h_cnt,
   input  logic [9:0]           v_cnt,
   output logic                 valid,
   output logic [6:0]           pixel_addr,
   output logic [NUM_SLOTS-1:0] live_mask,
   output logic                 fire_ack,
   output logic                 fire_drop
);

   localparam logic [9:0]  SPD_10   = 10'(SPD);
   localparam logic [10:0] SPD_11   = 11'(SPD);
   localparam logic [10:0] MAP_W_11 = 11'(MAP_W);
   localparam logic [10:0] MAP_H_11 = 11'(MAP_H);
   localparam logic [10:0] BW_11    = 11'(BW);
   localparam logic [10:0] BH_11    = 11'(BH);
   localparam logic [6:0]  BW_7     = 7'(BW);
   localparam logic [9:0]  OFS_FULL = 10'(PLYR_SZ);
   localparam logic [9:0]  OFS_HALF = 10'(PLYR_SZ / 2);
   localparam logic [7:0]  CD_LOAD  = 8'(COOLDOWN);

   // Active axes of a direction code, packed as {+x, -x, +y, -y}.
   function automatic logic [3:0] axes(input logic [2:0] d);
      case (d)
         3'd0:    axes = 4'b1001;
         3'd1:    axes = 4'b0110;
         3'd2:    axes = 4'b0010;
         3'd3:    axes = 4'b1010;
         3'd4:    axes = 4'b0100;
         3'd5:    axes = 4'b1000;
         3'd6:    axes = 4'b0101;
         3'd7:    axes = 4'b0001;
         default: axes = 4'b0000;
      endcase
   endfunction

   logic [NUM_SLOTS-1:0] live;
   logic [2:0]           dir [NUM_SLOTS];
   logic [9:0]           x   [NUM_SLOTS];
   logic [9:0]           y   [NUM_SLOTS];
   logic                 fire_q;
   logic [7:0]           cd;

   logic [NUM_SLOTS-1:0] live_nx;
   logic [2:0]           dir_nx [NUM_SLOTS];
   logic [9:0]           x_nx   [NUM_SLOTS];
   logic [9:0]           y_nx   [NUM_SLOTS];

   logic [3:0]           ax        [NUM_SLOTS];
   logic [6:0]           slot_addr [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] leave;
   logic [NUM_SLOTS-1:0] hit;
   logic [NUM_SLOTS-1:0] spawn_sel;
   logic                 found;
   logic                 req;
   logic                 accept;
   logic                 reject;
   logic [9:0]           off_x;
   logic [9:0]           off_y;
   logic [9:0]           spawn_x;
   logic [9:0]           spawn_y;

   assign req       = fire & ~fire_q;
   assign accept    = run & req & (cd == 8'd0) & found;
   assign reject    = run & req & ~((cd == 8'd0) & found);
   assign spawn_x   = plyr_x + off_x;
   assign spawn_y   = plyr_y + off_y;
   assign live_mask = live;

   // Per-slot edge test and render hit, all bound sums at 11 bits.
   for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign ax[gi]    = axes(dir[gi]);
      assign leave[gi] = (ax[gi][3] && ({1'b0, x[gi]} + SPD_11 >= MAP_W_11)) ||
                         (ax[gi][2] && ({1'b0, x[gi]} < SPD_11)) ||
                         (ax[gi][1] && ({1'b0, y[gi]} + SPD_11 >= MAP_H_11)) ||
                         (ax[gi][0] && ({1'b0, y[gi]} < SPD_11));
      assign hit[gi]   = live[gi] &&
                         (h_cnt >= x[gi]) && ({1'b0, h_cnt} < {1'b0, x[gi]} + BW_11) &&
                         (v_cnt >= y[gi]) && ({1'b0, v_cnt} < {1'b0, y[gi]} + BH_11);
      assign slot_addr[gi] = 7'(h_cnt - x[gi]) + 7'(v_cnt - y[gi]) * BW_7;
   end

   // Lowest-index free slot, judged on the registered live bits.
   always_comb begin
      spawn_sel = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!live[i] && !found) begin
            spawn_sel[i] = 1'b1;
            found        = 1'b1;
         end else begin
            spawn_sel[i] = 1'b0;
         end
      end
   end

   // Spawn offset from the player's top-left corner for each direction.
   always_comb begin
      case (fire_dir)
         3'd0:    begin off_x = OFS_FULL; off_y = 10'd0;    end
         3'd1:    begin off_x = 10'd0;    off_y = OFS_FULL; end
         3'd2:    begin off_x = OFS_HALF; off_y = OFS_FULL; end
         3'd3:    begin off_x = OFS_FULL; off_y = OFS_FULL; end
         3'd4:    begin off_x = 10'd0;    off_y = OFS_HALF; end
         3'd5:    begin off_x = OFS_FULL; off_y = OFS_HALF; end
         3'd6:    begin off_x = 10'd0;    off_y = 10'd0;    end
         3'd7:    begin off_x = OFS_HALF; off_y = 10'd0;    end
         default: begin off_x = 10'd0;    off_y = 10'd0;    end
      endcase
   end

   // Next slot state: run-low flush, spawn into the free slot, or move/retire on tick.
   always_comb begin
      live_nx = live;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         dir_nx[i] = dir[i];
         x_nx[i]   = x[i];
         y_nx[i]   = y[i];
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!run) begin
            live_nx[i] = 1'b0;
         end else if (accept && spawn_sel[i]) begin
            live_nx[i] = 1'b1;
            dir_nx[i]  = fire_dir;
            x_nx[i]    = spawn_x;
            y_nx[i]    = spawn_y;
         end else if (tick && live[i]) begin
            if (leave[i]) begin
               live_nx[i] = 1'b0;
            end else begin
               if (ax[i][3]) begin
                  x_nx[i] = x[i] + SPD_10;
               end else if (ax[i][2]) begin
                  x_nx[i] = x[i] - SPD_10;
               end else begin
                  x_nx[i] = x[i];
               end
               if (ax[i][1]) begin
                  y_nx[i] = y[i] + SPD_10;
               end else if (ax[i][0]) begin
                  y_nx[i] = y[i] - SPD_10;
               end else begin
                  y_nx[i] = y[i];
               end
            end
         end else begin
            live_nx[i] = live[i];
         end
      end
   end

   // Pixel output from the lowest-index hitting slot.
   always_comb begin
      valid      = 1'b0;
      pixel_addr = 7'd0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (hit[i]) begin
            valid      = 1'b1;
            pixel_addr = slot_addr[i];
         end else begin
            valid      = valid;
         end
      end
   end

   // Slot registers, fire edge detector, cooldown and handshake pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live      <= '0;
         fire_q    <= 1'b0;
         cd        <= 8'd0;
         fire_ack  <= 1'b0;
         fire_drop <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            dir[i] <= 3'd0;
            x[i]   <= 10'd0;
            y[i]   <= 10'd0;
         end
      end else begin
         live      <= live_nx;
         fire_q    <= fire;
         fire_ack  <= accept;
         fire_drop <= reject;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            dir[i] <= dir_nx[i];
            x[i]   <= x_nx[i];
            y[i]   <= y_nx[i];
         end
         if (!run) begin
            cd <= 8'd0;
         end else if (accept) begin
            cd <= CD_LOAD;
         end else if (tick && (cd != 8'd0)) begin
            cd <= cd - 8'd1;
         end else begin
            cd <= cd;
         end
      end
   end

endmodule

// File: doc/bullet_pool.md
# bullet_pool

Multi-bullet successor to the single-bullet controller in the Doodle Jump VGA game. It holds `NUM_SLOTS` independent projectiles, each fired from the player sprite in one of eight directions. Each projectile advances on a movement tick and retires when it would leave the map. A fire cooldown limits the firing rate. The block sits between the keypad direction decoder and the VGA pixel mux, and supplies a per-pixel hit flag plus the bullet sprite ROM address.

## Interface
- `NUM_SLOTS`, 4: number of simultaneous bullets, 1–8.
- `SPD`, 25: pixels moved per tick on each active axis.
- `MAP_W` / `MAP_H`, 640 / 480: playfield size.
- `BW` / `BH`, 10 / 11: bullet sprite width and height.
- `PLYR_SZ`, 60: player sprite size, used for spawn offsets.
- `COOLDOWN`, 4: ticks after an accepted shot before the next shot can be accepted.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `run`  in  1: high while the game state is "playing".
- `tick`  in  1: one-cycle movement strobe.
- `fire`  in  1: fire key level; only its rising edge counts.
- `fire_dir`  in  3: 0 up-right, 1 down-left, 2 down, 3 down-right, 4 left, 5 right, 6 up-left, 7 up.
- `plyr_x`, `plyr_y`  in  10 each: player top-left corner.
- `h_cnt`, `v_cnt`  in  10 each: VGA scan position.
- `valid`  out  1: the current pixel lies inside some live bullet.
- `pixel_addr`  out  7: bullet ROM address.
- `live_mask`  out  `NUM_SLOTS`: live bit per slot.
- `fire_ack`  out  1: one-cycle pulse, a shot was accepted.
- `fire_drop`  out  1: one-cycle pulse, a shot was rejected.

## Operation
- **Slot state.** Each slot holds `live`, `dir` (3 bits), `x` and `y` (10 bits each). All are 0 on reset.
- **Edge detect.** `fire_q` samples `fire` every cycle, including while `run` is low. A shot request is `fire & ~fire_q`.
- **Acceptance.** A request is accepted when `run`=1, the cooldown is 0, and some slot is free.
  - The target is the lowest-index free slot, judged by the `live` values before this cycle's updates.
  - A slot that retires in the same cycle cannot be reused in that cycle.
- **Spawn position** (x offset, y offset from `plyr_x`, `plyr_y`):
  - dir 1: (0, `PLYR_SZ`)
  - dir 2: (`PLYR_SZ`/2, `PLYR_SZ`)
  - dir 3: (`PLYR_SZ`, `PLYR_SZ`)
  - dir 4: (0, `PLYR_SZ`/2)
  - dir 5: (`PLYR_SZ`, `PLYR_SZ`/2)
  - dir 6: (0, 0)
  - dir 7: (`PLYR_SZ`/2, 0)
  - dir 0: (`PLYR_SZ`, 0)
- **Rejection.** A request with no free slot, or with a nonzero cooldown, pulses `fire_drop` and changes no other state.
- **Motion.** On `tick`, every live slot that was not spawned in this cycle moves.
  - +x for dirs 0, 3, 5; −x for dirs 1, 4, 6.
  - +y for dirs 1, 2, 3; −y for dirs 0, 6, 7.
- **Retirement.** On `tick`, a slot clears `live` and keeps its position if any active axis would cross a map edge:
  - +x: `x+SPD >= MAP_W`
  - −x: `x < SPD`
  - +y: `y+SPD >= MAP_H`
  - −y: `y < SPD`
  
  There is no partial-axis survival.
- **Cooldown.** The cooldown counter is loaded with `COOLDOWN` on accept. It decrements on each `tick` while nonzero and saturates at 0.
- **Run low.** While `run`=0, every `live` clears, the cooldown clears to 0, and requests are ignored with no ack and no drop.
- **Render** (combinational):
  - A slot hits the pixel when it is live, `x <= h_cnt < x+BW`, and `y <= v_cnt < y+BH`.
  - `valid` is the OR of all slot hits.
  - `pixel_addr` is `(h_cnt−x)+(v_cnt−y)*BW` for the lowest-index hitting slot, and 0 when `valid`=0.
- **Arithmetic width.** All bound sums are computed at 11 bits so that nothing wraps.

## Timing
- Reset values: all outputs 0, `fire_q`=0, cooldown 0.
- A request at cycle n gives, at cycle n+1: the slot live with its spawn position, `fire_ack`=1, and `live_mask` updated. `fire_drop` also appears at n+1.
- A slot moves at most once per `tick`. A slot spawned at cycle n first moves on a `tick` at cycle n+1 or later.
- `tick` and a request in the same cycle: existing slots move or retire, the new slot spawns unmoved, and the cooldown loads `COOLDOWN` (the load wins over the decrement).
- `valid` and `pixel_addr` follow the registered slot state with zero additional latency.
- `rst` asserted mid-flight clears all state immediately, without waiting for `clk`.

## Test plan
- **Single shot.** Reset, `run`=1, player at (100,200), `fire_dir`=5, one `fire` edge → at n+1 slot 0 at (160,230), `fire_ack`=1, `live_mask`=0001. After 3 ticks x=235.
- **Pool exhaustion.** `COOLDOWN`=0, 5 edges on 5 separate cycles → slots 0–3 fill in order, 5th edge gives `fire_drop`=1, `live_mask`=1111 unchanged.
- **Edge exit.** Slot at x=20 with dir 4, `tick` → `live`=0, x stays 20. Next edge reuses slot 0.
- **Cooldown.** `COOLDOWN`=4, fire, edge after 2 ticks → drop. Edge after 4 ticks → ack.
- **Run drop.** 3 live slots, `run`=0 for one cycle → `live_mask`=0000. A held `fire` does not refire when `run` returns.
- **Render overlap.** Slots 0 and 1 both covering (300,300) with slot 0 at (295,298) → `valid`=1, `pixel_addr`=25. Pixel (305,298) with no cover → `valid`=0, `pixel_addr`=0.
